// File: rtl/decode_execute.sv
// decode_execute: RV32I decode, ALU, branch/jump resolution and machine-mode CSR file
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset (CSR state only)
//   inst, inst_valid, pc     instruction word, commit strobe for the next edge, its address
//   rs1_value, rs2_value     register-file read data
//   rs1, rs2, rd, funct3     raw instruction fields
//   imm                      sign-extended immediate (0 for R-type)
//   R_wen, mem_wen, mem_ren  register write, store, load enables
//   *_flag                   instruction class decodes, inv_flag marks an illegal encoding
//   ex_result, mem_wdata     execute result / store data
//   npc                      next PC
//   mepc_out, mtvec_out      current CSR contents
module decode_execute #(
    parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_value,
    input  logic [31:0] rs2_value,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [2:0]  funct3,
    output logic        R_wen,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic        jump_flag,
    output logic        branch_flag,
    output logic        ecall_flag,
    output logic        mret_flag,
    output logic        ebreak_flag,
    output logic        inv_flag,
    output logic [31:0] ex_result,
    output logic [31:0] mem_wdata,
    output logic [31:0] npc,
    output logic [31:0] mepc_out,
    output logic [31:0] mtvec_out
);
    logic [6:0]  opcode, funct7;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
    logic        is_ecall, is_ebreak, is_mret, is_csrrw, is_csrrs, is_csr, taken;
    logic [31:0] alu_b, alu, pc4, csr_old, csr_wdata;
    logic [31:0] mstatus, mtvec, mepc, mcause;
    logic [11:0] csr_addr;

    assign opcode    = inst[6:0];
    assign funct7    = inst[31:25];
    assign funct3    = inst[14:12];
    assign rs1       = inst[19:15];
    assign rs2       = inst[24:20];
    assign rd        = inst[11:7];
    assign csr_addr  = inst[31:20];
    assign mem_wdata = rs2_value;
    assign pc4       = pc + 32'd4;

    assign is_lui    = opcode == 7'h37;
    assign is_auipc  = opcode == 7'h17;
    assign is_jal    = opcode == 7'h6F;
    assign is_jalr   = opcode == 7'h67 && funct3 == 3'b000;
    assign is_br     = opcode == 7'h63 && funct3[2:1] != 2'b01;
    assign is_ld     = opcode == 7'h03 && funct3 != 3'b011 && funct3[2:1] != 2'b11;
    assign is_st     = opcode == 7'h23 && funct3 < 3'd3;
    // shift-immediates carry funct7 in imm[11:5]; only SRAI may set bit 30
    assign is_opi    = opcode == 7'h13 && (funct3 == 3'b001 ? funct7 == 7'h00 :
                       funct3 == 3'b101 ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1);
    assign is_op     = opcode == 7'h33 && (funct7 == 7'h00 ||
                       (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
    assign is_ecall  = inst == 32'h0000_0073;
    assign is_ebreak = inst == 32'h0010_0073;
    assign is_mret   = inst == 32'h3020_0073;
    assign is_csrrw  = opcode == 7'h73 && funct3 == 3'b001;
    assign is_csrrs  = opcode == 7'h73 && funct3 == 3'b010;
    assign is_csr    = is_csrrw | is_csrrs;

    assign R_wen       = is_lui | is_auipc | is_jal | is_jalr | is_ld | is_op | is_opi | is_csr;
    assign mem_wen     = is_st;
    assign mem_ren     = is_ld;
    assign jump_flag   = is_jal | is_jalr;
    assign branch_flag = is_br;
    assign ecall_flag  = is_ecall;
    assign mret_flag   = is_mret;
    assign ebreak_flag = is_ebreak;
    assign inv_flag    = ~(is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st |
                           is_opi | is_op | is_ecall | is_ebreak | is_mret | is_csr);

    // format chosen by opcode alone; everything else (incl. SYSTEM) uses I-type
    assign imm = (is_lui | is_auipc) ? {inst[31:12], 12'b0} :
                 opcode == 7'h6F ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
                 opcode == 7'h63 ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                 opcode == 7'h23 ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                 opcode == 7'h33 ? 32'd0 : {{20{inst[31]}}, inst[31:20]};

    assign alu_b = is_op ? rs2_value : imm;

    // inst[30] selects SUB (OP only) and arithmetic right shift (OP and OP-IMM)
    always_comb begin
        case (funct3)
            3'b000:  alu = (is_op && inst[30]) ? rs1_value - alu_b : rs1_value + alu_b;
            3'b001:  alu = rs1_value << alu_b[4:0];
            3'b010:  alu = {31'd0, $signed(rs1_value) < $signed(alu_b)};
            3'b011:  alu = {31'd0, rs1_value < alu_b};
            3'b100:  alu = rs1_value ^ alu_b;
            3'b101:  alu = inst[30] ? $unsigned($signed(rs1_value) >>> alu_b[4:0]) : rs1_value >> alu_b[4:0];
            3'b110:  alu = rs1_value | alu_b;
            default: alu = rs1_value & alu_b;
        endcase
    end

    // funct3[0] inverts the base comparison: BNE/BGE/BGEU
    assign taken = (funct3[2] ? (funct3[1] ? rs1_value < rs2_value : $signed(rs1_value) < $signed(rs2_value))
                              : rs1_value == rs2_value) ^ funct3[0];

    assign csr_old = csr_addr == 12'h300 ? mstatus :
                     csr_addr == 12'h305 ? mtvec :
                     csr_addr == 12'h341 ? mepc :
                     csr_addr == 12'h342 ? mcause : 32'd0;
    assign csr_wdata = is_csrrw ? rs1_value : csr_old | rs1_value;

    assign ex_result = is_lui ? imm :
                       is_auipc ? pc + imm :
                       jump_flag ? pc4 :
                       (is_ld | is_st) ? rs1_value + imm :
                       (is_op | is_opi) ? alu :
                       is_csr ? csr_old :
                       is_br ? {31'd0, taken} : 32'd0;

    assign npc = is_mret ? mepc :
                 is_ecall ? mtvec :
                 is_jal ? pc + imm :
                 is_jalr ? (rs1_value + imm) & ~32'd1 :
                 (is_br && taken) ? pc + imm : pc4;

    assign mepc_out  = mepc;
    assign mtvec_out = mtvec;

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus <= MSTATUS_RST;
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else if (inst_valid) begin
            if (is_csr && csr_addr == 12'h300) mstatus <= csr_wdata;
            if (is_csr && csr_addr == 12'h305) mtvec <= csr_wdata;
            if (is_ecall) begin
                mepc   <= pc;
                mcause <= 32'd11;
            end else begin
                if (is_csr && csr_addr == 12'h341) mepc <= csr_wdata;
                if (is_csr && csr_addr == 12'h342) mcause <= csr_wdata;
            end
        end
    end
endmodule

// File: tb/tb_decode_execute.sv
// tb_decode_execute: directed self-checking bench for decode_execute
module tb_decode_execute;
    logic        clk = 1'b0, rst = 1'b1, inst_valid = 1'b0;
    logic [31:0] inst = 32'h0000_0013, pc = '0, rs1_value = '0, rs2_value = '0;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, ex_result, mem_wdata, npc, mepc_out, mtvec_out;
    logic [2:0]  funct3;
    logic        R_wen, mem_wen, mem_ren, jump_flag, branch_flag, ecall_flag, mret_flag, ebreak_flag, inv_flag;
    int          passed = 0, total = 0;

    decode_execute dut (
        .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .pc(pc),
        .rs1_value(rs1_value), .rs2_value(rs2_value), .rs1(rs1), .rs2(rs2), .rd(rd),
        .imm(imm), .funct3(funct3), .R_wen(R_wen), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .jump_flag(jump_flag), .branch_flag(branch_flag), .ecall_flag(ecall_flag),
        .mret_flag(mret_flag), .ebreak_flag(ebreak_flag), .inv_flag(inv_flag),
        .ex_result(ex_result), .mem_wdata(mem_wdata), .npc(npc),
        .mepc_out(mepc_out), .mtvec_out(mtvec_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] csr_inst(input logic [11:0] a, input logic [2:0] f3);
        return {a, 5'd1, f3, 5'd5, 7'h73};
    endfunction

    task automatic drive(input logic [31:0] i, p, a, b, input logic v);
        @(negedge clk);
        inst = i; pc = p; rs1_value = a; rs2_value = b; inst_valid = v;
        #1;
    endtask

    task automatic commit;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(csr_inst(12'h305, 3'b001), 32'h0, 32'h0000_1234, 32'h0, 1'b1);
        commit();
        total++; if (mtvec_out !== 32'h0) $display("FAIL reset_mtvec got=%h exp=0", mtvec_out); else passed++;
        total++; if (mepc_out !== 32'h0) $display("FAIL reset_mepc got=%h exp=0", mepc_out); else passed++;
        drive(csr_inst(12'h300, 3'b010), 32'h0, 32'h0, 32'h0, 1'b0);
        total++; if (ex_result !== 32'h1800) $display("FAIL reset_mstatus got=%h exp=1800", ex_result); else passed++;
        rst = 1'b0;
        drive(csr_inst(12'h342, 3'b010), 32'h0, 32'h0, 32'h0, 1'b0);
        total++; if (ex_result !== 32'h0) $display("FAIL reset_mcause got=%h exp=0", ex_result); else passed++;
    endtask

    task automatic test_addi;
        drive(32'h0050_0093, 32'h100, 32'h0, 32'h0, 1'b0);
        total++; if (rd !== 5'd1) $display("FAIL addi_rd got=%0d exp=1", rd); else passed++;
        total++; if (imm !== 32'd5) $display("FAIL addi_imm got=%h exp=5", imm); else passed++;
        total++; if (R_wen !== 1'b1) $display("FAIL addi_rwen got=%b exp=1", R_wen); else passed++;
        total++; if (ex_result !== 32'd5) $display("FAIL addi_ex got=%h exp=5", ex_result); else passed++;
        total++; if (npc !== 32'h104) $display("FAIL addi_npc got=%h exp=104", npc); else passed++;
        total++; if (inv_flag !== 1'b0) $display("FAIL addi_inv got=%b exp=0", inv_flag); else passed++;
    endtask

    task automatic test_alu;
        drive({7'h20, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 32'h0, 32'd5, 32'd7, 1'b0);
        total++; if (ex_result !== 32'hFFFF_FFFE) $display("FAIL sub_ex got=%h exp=fffffffe", ex_result); else passed++;
        total++; if ({rs1, rs2, rd, funct3} !== {5'd1, 5'd2, 5'd3, 3'd0}) $display("FAIL sub_fields got=%h exp=%h", {rs1, rs2, rd, funct3}, {5'd1, 5'd2, 5'd3, 3'd0}); else passed++;
        total++; if (imm !== 32'h0) $display("FAIL rtype_imm got=%h exp=0", imm); else passed++;
        drive({7'h20, 5'd2, 5'd1, 3'b101, 5'd3, 7'h33}, 32'h0, 32'h8000_0000, 32'h21, 1'b0);
        total++; if (ex_result !== 32'hC000_0000) $display("FAIL sra_ex got=%h exp=c0000000", ex_result); else passed++;
        drive({7'h00, 5'd2, 5'd1, 3'b010, 5'd3, 7'h33}, 32'h0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        total++; if (ex_result !== 32'd1) $display("FAIL slt_ex got=%h exp=1", ex_result); else passed++;
        drive({7'h00, 5'd2, 5'd1, 3'b011, 5'd3, 7'h33}, 32'h0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        total++; if (ex_result !== 32'd0) $display("FAIL sltu_ex got=%h exp=0", ex_result); else passed++;
        drive({7'h20, 5'd4, 5'd1, 3'b101, 5'd1, 7'h13}, 32'h0, 32'hF000_0000, 32'h0, 1'b0);
        total++; if (ex_result !== 32'hFF00_0000) $display("FAIL srai_ex got=%h exp=ff000000", ex_result); else passed++;
        drive({7'h01, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 32'h0, 32'd5, 32'd7, 1'b0);
        total++; if (inv_flag !== 1'b1) $display("FAIL mul_inv got=%b exp=1", inv_flag); else passed++;
    endtask

    task automatic test_branch;
        drive({7'd0, 5'd2, 5'd1, 3'b001, 5'b01000, 7'h63}, 32'h8000_0000, 32'd1, 32'd2, 1'b0);
        total++; if (imm !== 32'd8) $display("FAIL bne_imm got=%h exp=8", imm); else passed++;
        total++; if (npc !== 32'h8000_0008) $display("FAIL bne_taken_npc got=%h exp=80000008", npc); else passed++;
        total++; if ({branch_flag, R_wen, ex_result[0]} !== 3'b101) $display("FAIL bne_flags got=%b exp=101", {branch_flag, R_wen, ex_result[0]}); else passed++;
        drive({7'd0, 5'd2, 5'd1, 3'b001, 5'b01000, 7'h63}, 32'h8000_0000, 32'd2, 32'd2, 1'b0);
        total++; if (npc !== 32'h8000_0004) $display("FAIL bne_nt_npc got=%h exp=80000004", npc); else passed++;
        total++; if (ex_result !== 32'd0) $display("FAIL bne_nt_ex got=%h exp=0", ex_result); else passed++;
        drive({7'd0, 5'd2, 5'd1, 3'b100, 5'b01000, 7'h63}, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 1'b0);
        total++; if (npc !== 32'h8000_0008) $display("FAIL blt_npc got=%h exp=80000008", npc); else passed++;
        drive({7'd0, 5'd2, 5'd1, 3'b110, 5'b01000, 7'h63}, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 1'b0);
        total++; if (npc !== 32'h8000_0004) $display("FAIL bltu_npc got=%h exp=80000004", npc); else passed++;
    endtask

    task automatic test_jumps;
        drive({12'd2, 5'd5, 3'b000, 5'd1, 7'h67}, 32'h200, 32'h8000_0101, 32'h0, 1'b0);
        total++; if (npc !== 32'h8000_0102) $display("FAIL jalr_npc got=%h exp=80000102", npc); else passed++;
        total++; if (ex_result !== 32'h204) $display("FAIL jalr_ex got=%h exp=204", ex_result); else passed++;
        total++; if ({R_wen, jump_flag} !== 2'b11) $display("FAIL jalr_flags got=%b exp=11", {R_wen, jump_flag}); else passed++;
        drive({1'b1, 10'h3FE, 1'b1, 8'hFF, 5'd1, 7'h6F}, 32'h1000, 32'h0, 32'h0, 1'b0);
        total++; if (imm !== 32'hFFFF_FFFC) $display("FAIL jal_imm got=%h exp=fffffffc", imm); else passed++;
        total++; if (npc !== 32'h0000_0FFC) $display("FAIL jal_npc got=%h exp=ffc", npc); else passed++;
        total++; if (ex_result !== 32'h1004) $display("FAIL jal_ex got=%h exp=1004", ex_result); else passed++;
    endtask

    task automatic test_mem_upper;
        drive({12'hFFC, 5'd3, 3'b010, 5'd2, 7'h03}, 32'h0, 32'h1000, 32'h0, 1'b0);
        total++; if (ex_result !== 32'h0FFC) $display("FAIL lw_addr got=%h exp=ffc", ex_result); else passed++;
        total++; if ({mem_ren, mem_wen, R_wen} !== 3'b101) $display("FAIL lw_en got=%b exp=101", {mem_ren, mem_wen, R_wen}); else passed++;
        drive({7'd0, 5'd2, 5'd3, 3'b010, 5'd8, 7'h23}, 32'h0, 32'h1000, 32'h0000_DEAD, 1'b0);
        total++; if (ex_result !== 32'h1008) $display("FAIL sw_addr got=%h exp=1008", ex_result); else passed++;
        total++; if (mem_wdata !== 32'h0000_DEAD) $display("FAIL sw_wdata got=%h exp=dead", mem_wdata); else passed++;
        total++; if ({mem_ren, mem_wen, R_wen} !== 3'b010) $display("FAIL sw_en got=%b exp=010", {mem_ren, mem_wen, R_wen}); else passed++;
        drive({20'h12345, 5'd1, 7'h37}, 32'h10, 32'h0, 32'h0, 1'b0);
        total++; if (ex_result !== 32'h1234_5000) $display("FAIL lui_ex got=%h exp=12345000", ex_result); else passed++;
        drive({20'h12345, 5'd1, 7'h17}, 32'h10, 32'h0, 32'h0, 1'b0);
        total++; if (ex_result !== 32'h1234_5010) $display("FAIL auipc_ex got=%h exp=12345010", ex_result); else passed++;
    endtask

    task automatic test_csr_ecall;
        drive(csr_inst(12'h305, 3'b001), 32'h0, 32'h8000_1000, 32'h0, 1'b0);
        commit();
        total++; if (mtvec_out !== 32'h0) $display("FAIL csr_novalid got=%h exp=0", mtvec_out); else passed++;
        drive(csr_inst(12'h305, 3'b001), 32'h0, 32'h8000_1000, 32'h0, 1'b1);
        total++; if (ex_result !== 32'h0) $display("FAIL csrrw_old got=%h exp=0", ex_result); else passed++;
        commit();
        total++; if (mtvec_out !== 32'h8000_1000) $display("FAIL csrrw_mtvec got=%h exp=80001000", mtvec_out); else passed++;
        drive(32'h0000_0073, 32'h8000_0020, 32'h0, 32'h0, 1'b1);
        total++; if (npc !== 32'h8000_1000) $display("FAIL ecall_npc got=%h exp=80001000", npc); else passed++;
        total++; if ({ecall_flag, R_wen, inv_flag} !== 3'b100) $display("FAIL ecall_flags got=%b exp=100", {ecall_flag, R_wen, inv_flag}); else passed++;
        commit();
        total++; if (mepc_out !== 32'h8000_0020) $display("FAIL ecall_mepc got=%h exp=80000020", mepc_out); else passed++;
        drive(csr_inst(12'h342, 3'b010), 32'h0, 32'h0, 32'h0, 1'b0);
        total++; if (ex_result !== 32'd11) $display("FAIL ecall_mcause got=%h exp=b", ex_result); else passed++;
        drive(32'h3020_0073, 32'h8000_1000, 32'h0, 32'h0, 1'b1);
        total++; if (npc !== 32'h8000_0020) $display("FAIL mret_npc got=%h exp=80000020", npc); else passed++;
        commit();
        total++; if ({mepc_out, mtvec_out} !== {32'h8000_0020, 32'h8000_1000}) $display("FAIL mret_csrs got=%h exp=%h", {mepc_out, mtvec_out}, {32'h8000_0020, 32'h8000_1000}); else passed++;
        drive(csr_inst(12'h300, 3'b010), 32'h0, 32'h0000_0008, 32'h0, 1'b1);
        total++; if (ex_result !== 32'h1800) $display("FAIL csrrs_old got=%h exp=1800", ex_result); else passed++;
        commit();
        drive(csr_inst(12'h300, 3'b010), 32'h0, 32'h0, 32'h0, 1'b0);
        total++; if (ex_result !== 32'h1808) $display("FAIL csrrs_new got=%h exp=1808", ex_result); else passed++;
        drive(csr_inst(12'h123, 3'b010), 32'h0, 32'h0, 32'h0, 1'b0);
        total++; if (ex_result !== 32'h0) $display("FAIL csr_unmapped got=%h exp=0", ex_result); else passed++;
    endtask

    task automatic test_ebreak_illegal;
        drive(32'h0010_0073, 32'h40, 32'h0, 32'h0, 1'b1);
        total++; if (ebreak_flag !== 1'b1) $display("FAIL ebreak_flag got=%b exp=1", ebreak_flag); else passed++;
        total++; if (npc !== 32'h44) $display("FAIL ebreak_npc got=%h exp=44", npc); else passed++;
        total++; if ({mem_wen, mem_ren, ecall_flag, mret_flag, inv_flag} !== 5'b0) $display("FAIL ebreak_others got=%b exp=00000", {mem_wen, mem_ren, ecall_flag, mret_flag, inv_flag}); else passed++;
        commit();
        total++; if ({mepc_out, mtvec_out} !== {32'h8000_0020, 32'h8000_1000}) $display("FAIL ebreak_csrs got=%h exp=%h", {mepc_out, mtvec_out}, {32'h8000_0020, 32'h8000_1000}); else passed++;
        drive(32'h0000_007F, 32'h80, 32'h5, 32'h6, 1'b0);
        total++; if (inv_flag !== 1'b1) $display("FAIL ill_inv got=%b exp=1", inv_flag); else passed++;
        total++; if ({R_wen, mem_wen, mem_ren, jump_flag, branch_flag} !== 5'b0) $display("FAIL ill_en got=%b exp=00000", {R_wen, mem_wen, mem_ren, jump_flag, branch_flag}); else passed++;
        total++; if (npc !== 32'h84) $display("FAIL ill_npc got=%h exp=84", npc); else passed++;
        drive(32'h0020_0073, 32'h80, 32'h0, 32'h0, 1'b0);
        total++; if ({inv_flag, ebreak_flag} !== 2'b10) $display("FAIL ill_system got=%b exp=10", {inv_flag, ebreak_flag}); else passed++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_addi();
        test_alu();
        test_branch();
        test_jumps();
        test_mem_upper();
        test_csr_ecall();
        test_ebreak_illegal();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/decode_execute.md
DECODE_EXECUTE -- requirements
Module: decode_execute

Interface
REQ-001 SHALL have parameter MSTATUS_RST, default 32'h0000_1800, giving the mstatus reset value.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for CSR state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 inst  in  32  RV32I instruction word, valid this cycle.
REQ-006 inst_valid  in  1  instruction commits at the next rising edge; gates all CSR updates.
REQ-007 pc  in  32  address of inst.
REQ-008 rs1_value, rs2_value  in  32 each  register-file read data for rs1/rs2.
REQ-009 rs1, rs2, rd  out  5 each  inst[19:15], inst[24:20], inst[11:7].
REQ-010 imm  out  32  sign-extended immediate per format (I/S/B/U/J); 0 for R-type.
REQ-011 funct3  out  3  inst[14:12].
REQ-012 R_wen, mem_wen, mem_ren  out  1 each  register-write, store, and load enables.
REQ-013 jump_flag, branch_flag, ecall_flag, mret_flag, ebreak_flag, inv_flag  out  1 each  class decodes; inv_flag flags an illegal instruction.
REQ-014 ex_result  out  32  ALU result, memory address, link value, or old CSR value.
REQ-015 mem_wdata  out  32  rs2_value.
REQ-016 npc  out  32  next PC.
REQ-017 mepc_out, mtvec_out  out  32 each  current CSR contents.

Function
REQ-018 Decode SHALL be purely combinational from inst.
REQ-019 Supported instructions SHALL be:
- LUI, AUIPC, JAL, JALR;
- BEQ/BNE/BLT/BGE/BLTU/BGEU;
- LB/LH/LW/LBU/LHU and SB/SH/SW;
- all OP-IMM and OP (RV32I);
- ECALL, EBREAK, MRET, CSRRW, CSRRS.
REQ-020 For any other encoding, inv_flag SHALL be 1, all enables 0, and npc=pc+4.
REQ-021 ex_result by class:
- LUI: imm.
- AUIPC: pc+imm.
- JAL/JALR: pc+4.
- Load/store: rs1_value+imm.
- OP/OP-IMM: ALU of rs1_value with rs2_value or imm.
- CSR: old CSR value.
- Branch: 1 if the condition holds, else 0.
REQ-022 ALU arithmetic SHALL be mod 2^32; shift amount = low 5 bits; SRA/SRAI sign-fill; SLT signed, SLTU unsigned.
REQ-023 R_wen SHALL be 1 for LUI, AUIPC, JAL, JALR, loads, OP, OP-IMM and CSR instructions, else 0; rd=0 is not special-cased here.
REQ-024 npc priority SHALL be:
1. mret: mepc.
2. ecall: mtvec.
3. JAL: pc+imm.
4. JALR: (rs1_value+imm)&~1.
5. Taken branch: pc+imm.
6. Otherwise: pc+4.
REQ-025 CSR addresses SHALL be mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342; other addresses read 0 and ignore writes.
REQ-026 CSRRW SHALL write rs1_value; CSRRS SHALL write old|rs1_value.
REQ-027 ECALL SHALL set mepc=pc and mcause=11 at the edge.
REQ-028 MRET and EBREAK SHALL modify no CSR.
REQ-029 CSR writes SHALL occur only at the rising edge with inst_valid=1.
REQ-030 CSR reads in the same cycle SHALL return pre-write values.
REQ-031 ebreak_flag SHALL be 1 only for inst=32'h0010_0073; other outputs SHALL be as for a NOP with npc=pc+4.

Reset
REQ-032 With rst=1 at a rising edge: mstatus=MSTATUS_RST, mtvec=0, mepc=0, mcause=0.
REQ-033 Reset SHALL take priority over any same-edge CSR write.
REQ-034 Combinational outputs SHALL remain a function of the inputs during reset.

Verification
REQ-035 ADDI: inst=32'h0050_0093 (addi x1,x0,5), rs1_value=0 -> rd=1, imm=5, R_wen=1, ex_result=5, npc=pc+4.
REQ-036 BNE: pc=0x8000_0000, imm=+8, rs1_value=1, rs2_value=2 -> npc=0x8000_0008; with equal operands -> npc=0x8000_0004.
REQ-037 JALR: rs1_value=0x8000_0101, imm=2 -> npc=0x8000_0102, ex_result=pc+4, R_wen=1.
REQ-038 CSR/ECALL: CSRRW mtvec with rs1_value=0x8000_1000 committed, then ECALL at pc=0x8000_0020 -> npc=0x8000_1000; after the edge mepc=0x8000_0020, mcause=11; then MRET -> npc=0x8000_0020.
REQ-039 Reset/ebreak: reset -> mstatus reads 0x1800; EBREAK -> ebreak_flag=1, no CSR change; illegal opcode 7'h7F -> inv_flag=1, all enables 0.
